// File: rtl/store_unit.sv
// Store unit: computes the effective address, lane-aligns store data and
// drives a single write handshake with timeout and misalignment faults.
module store_unit #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [1:0]  store_control,
  input  logic        mem_ready,
  output logic        stall_pc,
  output logic        ignore_curr_inst,
  output logic        mem_rw_mode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        store_done,
  output logic        store_fault,
  output logic [1:0]  fault_cause
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0] r_wait;
  logic          r_rw;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [1:0]    r_cause;

  logic [31:0] w_ea;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic        w_aligned;
  logic        w_req;
  logic        w_sb;
  logic        w_sh;
  logic        w_sw;
  logic        w_wait_max;

  assign w_ea  = rs1_val + imm;
  assign w_req = (store_control != 2'b00);
  assign w_sb  = (store_control == 2'b01);
  assign w_sh  = (store_control == 2'b10);
  assign w_sw  = (store_control == 2'b11);

  // Counter reaches MAX_WAIT on the edge ending this cycle
  assign w_wait_max = (r_wait == CW'(MAX_WAIT - 1));

  always_comb begin
    w_aligned = 1'b0;
    w_wdata   = '0;
    w_wstrb   = '0;
    unique case (1'b1)
      w_sb: begin
        w_aligned = 1'b1;
        w_wdata   = {4{rs2_val[7:0]}};
        w_wstrb   = 4'b0001 << w_ea[1:0];
      end
      w_sh: begin
        w_aligned = ~w_ea[0];
        w_wdata   = {2{rs2_val[15:0]}};
        w_wstrb   = w_ea[1] ? 4'b1100 : 4'b0011;
      end
      w_sw: begin
        w_aligned = (w_ea[1:0] == 2'b00);
        w_wdata   = rs2_val;
        w_wstrb   = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req)
          w_next = w_aligned ? S_WRITE : S_FAULT;
      end
      S_WRITE: begin
        if (mem_ready)
          w_next = S_DONE;
        else if (w_wait_max)
          w_next = S_FAULT;
      end
      S_DONE:  w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_rw    <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_req && w_aligned) begin
            r_addr  <= {w_ea[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_rw    <= 1'b0;
            r_wait  <= '0;
          end else if (w_req) begin
            r_cause <= 2'b01;
          end
        end
        S_WRITE: begin
          // A late mem_ready still wins over the timeout
          if (mem_ready || w_wait_max) begin
            r_rw    <= 1'b1;
            r_wstrb <= '0;
            if (!mem_ready)
              r_cause <= 2'b10;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rw_mode      = r_rw;
  assign mem_addr         = r_addr;
  assign mem_wdata        = r_wdata;
  assign mem_wstrb        = r_wstrb;
  assign store_done       = (r_state == S_DONE);
  assign store_fault      = (r_state == S_FAULT);
  assign fault_cause      = store_fault ? r_cause : 2'b00;
  assign ignore_curr_inst = store_done | store_fault;
  assign stall_pc         = ((r_state == S_IDLE) && w_req) ||
                            (r_state == S_WRITE);

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: stimulus pushes expected outcomes,
// a negedge monitor pops and compares them.
module tb_store_unit;

  localparam int MAXW = 15;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic [31:0] imm = '0;
  logic [1:0]  store_control = '0;
  logic        mem_ready = 1'b0;
  logic        stall_pc;
  logic        ignore_curr_inst;
  logic        mem_rw_mode;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        store_done;
  logic        store_fault;
  logic [1:0]  fault_cause;

  store_unit #(.MAX_WAIT(MAXW)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .imm              (imm),
    .store_control    (store_control),
    .mem_ready        (mem_ready),
    .stall_pc         (stall_pc),
    .ignore_curr_inst (ignore_curr_inst),
    .mem_rw_mode      (mem_rw_mode),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .store_done       (store_done),
    .store_fault      (store_fault),
    .fault_cause      (fault_cause)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          flt;
    logic [1:0]  cause;
    int          nw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  bit   exp_stall = 1'b0;
  bit   exp_ign = 1'b0;
  bit   stim_done = 1'b0;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] ctl, input logic [31:0] a,
                       input logic [31:0] o, input logic [31:0] d,
                       input int w);
    exp_t        e;
    logic [31:0] ea;
    int          sz;
    ea = a + o;
    sz = (ctl == 2'd1) ? 1 : (ctl == 2'd2) ? 2 : 4;
    e.addr = '0;
    e.data = '0;
    e.strb = '0;
    if ((ea % sz) != 0) begin
      e.flt   = 1'b1;
      e.cause = 2'b01;
      e.nw    = 0;
    end else begin
      e.addr = ea - (ea % 4);
      if (sz == 1)
        e.data = (d & 32'hFF) * 32'h0101_0101;
      else if (sz == 2)
        e.data = (d & 32'hFFFF) * 32'h0001_0001;
      else
        e.data = d;
      e.strb  = 4'(((1 << sz) - 1) << (ea % 4));
      e.flt   = (w >= MAXW);
      e.cause = e.flt ? 2'b10 : 2'b00;
      e.nw    = e.flt ? MAXW : w + 1;
    end
    sbq.push_back(e);
    store_control = ctl;
    rs1_val = a;
    imm = o;
    rs2_val = d;
    mem_ready = 1'($urandom);
    exp_stall = 1'b1;
    exp_ign = 1'b0;
    step();
    for (int i = 1; i <= e.nw; i++) begin
      store_control = 2'($urandom);
      rs1_val = $urandom;
      rs2_val = $urandom;
      imm = $urandom;
      mem_ready = (i > w);
      exp_stall = 1'b1;
      exp_ign = 1'b0;
      step();
    end
    store_control = 2'($urandom);
    mem_ready = 1'($urandom);
    exp_stall = 1'b0;
    exp_ign = 1'b1;
    step();
    store_control = 2'b00;
    exp_stall = 1'b0;
    exp_ign = 1'b0;
  endtask

  initial begin
    logic [1:0]  ctl;
    logic [31:0] ofs;
    int          w;
    step();
    store_control = 2'b11;
    exp_stall = 1'b1;
    step();
    store_control = 2'b00;
    exp_stall = 1'b0;
    i_rst = 1'b1;
    step();
    issue(2'b11, 32'h1000, 32'h8, 32'hDEAD_BEEF, 0);
    issue(2'b01, 32'h2000, 32'h3, 32'h0000_00A5, 0);
    issue(2'b10, 32'h3000, 32'h2, 32'h0000_1234, 3);
    issue(2'b11, 32'h4000, 32'h1, 32'h1111_2222, 0);
    issue(2'b11, 32'h5000, 32'h0, 32'hCAFE_F00D, 20);
    issue(2'b11, 32'h5004, 32'h0, 32'h0BAD_CAFE, MAXW - 1);
    issue(2'b11, 32'h5008, 32'h0, 32'h0BAD_CAFE, MAXW);
    issue(2'b01, 32'h2000, 32'h0, 32'h0000_0037, 1);
    issue(2'b01, 32'h2000, 32'h1, 32'h0000_0048, 0);
    issue(2'b10, 32'h3000, 32'h0, 32'h0000_ABCD, 0);
    issue(2'b10, 32'h3000, 32'h1, 32'h0000_ABCD, 0);
    issue(2'b11, 32'h0000_0100, 32'hFFFF_FFFC, 32'h1234_5678, 2);
    issue(2'b11, 32'hFFFF_FFFC, 32'h8, 32'h8765_4321, 0);
    store_control = 2'b11;
    rs1_val = 32'h6000;
    imm = 32'h0;
    rs2_val = 32'h5555_AAAA;
    mem_ready = 1'b0;
    exp_stall = 1'b1;
    step();
    store_control = 2'b00;
    step();
    i_rst = 1'b0;
    exp_stall = 1'b0;
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    step();
    issue(2'b11, 32'h6000, 32'h4, 32'h7777_8888, 1);
    for (int k = 0; k < 150; k++) begin
      ctl = 2'($urandom_range(1, 3));
      ofs = 32'($urandom_range(0, 63)) - 32'd32;
      w = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3)
                                     : $urandom_range(12, 17);
      issue(ctl, $urandom, ofs, $urandom, w);
      if ($urandom_range(0, 3) == 0)
        step();
    end
    repeat (3) step();
    stim_done = 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int          n;
    int          cyc;
    bit          trk;
    bit          unst;
    logic [31:0] ca;
    logic [31:0] cd;
    logic [3:0]  cs;
    exp_t        e;
    n = 0;
    cyc = 0;
    trk = 1'b0;
    unst = 1'b0;
    ca = '0;
    cd = '0;
    cs = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      chk("stall_pc", 32'(stall_pc), 32'(exp_stall));
      chk("ignore_curr_inst", 32'(ignore_curr_inst), 32'(exp_ign));
      if (!i_rst) begin
        chk("rst_rw_mode", 32'(mem_rw_mode), 32'd1);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_done", 32'(store_done), 32'd0);
        chk("rst_fault", 32'(store_fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        trk = 1'b0;
        unst = 1'b0;
        n = 0;
      end else begin
        chk("done_fault_excl", 32'(store_done & store_fault), 32'd0);
        if (mem_rw_mode) begin
          chk("idle_wstrb", 32'(mem_wstrb), 32'd0);
        end else begin
          if (!trk) begin
            ca = mem_addr;
            cd = mem_wdata;
            cs = mem_wstrb;
            trk = 1'b1;
          end else if (mem_addr !== ca || mem_wdata !== cd ||
                       mem_wstrb !== cs) begin
            unst = 1'b1;
          end
          n++;
        end
        if (store_done || store_fault) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: got done=%0b fault=%0b expected none",
                     store_done, store_fault);
          end else begin
            e = sbq.pop_front();
            chk("outcome_fault", 32'(store_fault), 32'(e.flt));
            if (e.flt)
              chk("fault_cause", 32'(fault_cause), 32'(e.cause));
            chk("write_cycles", n, e.nw);
            if (e.nw > 0) begin
              chk("mem_addr", ca, e.addr);
              chk("mem_wdata", cd, e.data);
              chk("mem_wstrb", 32'(cs), 32'(e.strb));
              chk("write_stable", 32'(unst), 32'd0);
            end
          end
          trk = 1'b0;
          unst = 1'b0;
          n = 0;
        end
      end
      if (stim_done || cyc > 50000) begin
        if (!stim_done) begin
          failures++;
          $display("FAIL timeout: got %0d cycles expected completion", cyc);
        end
        chk("pending_expect", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

endmodule
